// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared widths, frame marker, loader states and first-byte mask helper
package instr_mem_loader_pkg;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_INSTR_WIDTH = 28;
    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
    typedef enum logic [2:0] {IDLE, HDR, CNT_H, CNT_L, DATA, CHK, DONE, ERR} state_t;
    // bits of a word's first byte that fall above the instruction width and must be zero
    function automatic logic [7:0] first_byte_mask(input int width);
        return 8'hFF << (width - 24);
    endfunction
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: host byte link, instruction RAM write port and CPU status of the loader
interface instr_mem_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int INSTR_WIDTH = 28
);
    logic start;
    logic [7:0] data;
    logic byte_valid;
    logic byte_ready;
    logic write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [INSTR_WIDTH-1:0] write_instruction;
    logic cpu_hold;
    logic done;
    logic error;
    modport master(
        input start, data, byte_valid,
        output byte_ready, write_enable, write_address, write_instruction, cpu_hold, done, error
    );
    modport slave(
        output start, data, byte_valid,
        input byte_ready, write_enable, write_address, write_instruction, cpu_hold, done, error
    );
endinterface

// File: rtl/instr_word_packer.sv
// instr_word_packer: shifts bytes MSB first into a word and pulses ready after the 4th byte
module instr_word_packer #(
    parameter int INSTR_WIDTH = 28
) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic shift,
    input logic [7:0] din,
    output logic [INSTR_WIDTH-1:0] word,
    output logic [1:0] idx,
    output logic ready
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
            idx <= '0;
            ready <= 1'b0;
        end else begin
            ready <= shift && idx == 2'd3;
            if (clr) begin
                word <= '0;
                idx <= '0;
            end else if (shift) begin
                word <= {word[INSTR_WIDTH-9:0], din};
                idx <= idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: unpacks a framed byte stream into instruction RAM writes while holding the CPU
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input logic clk,
    input logic rst,
    instr_mem_loader_if.master bus
);
    localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
    state_t state, nx;
    logic active, done, error, we, xfer, in_data, bad, shift, last, range_bad;
    logic [1:0] idx;
    logic [15:0] n, n_cl;
    logic [16:0] wcnt;
    logic [7:0] sum;
    logic [ADDR_WIDTH-1:0] addr;
    logic [INSTR_WIDTH-1:0] word;
    // a byte arriving together with start is dropped
    assign xfer = bus.byte_valid & active & ~bus.start;
    assign in_data = xfer && state == DATA;
    assign bad = in_data && idx == 2'd0 && (bus.data & first_byte_mask(INSTR_WIDTH)) != 8'd0;
    assign shift = in_data && !bad;
    assign last = shift && idx == 2'd3;
    assign n_cl = {n[15:8], bus.data};
    assign range_bad = {17'd0, n_cl} > MAX_WORDS;
    instr_word_packer #(.INSTR_WIDTH(INSTR_WIDTH)) packer (
        .clk(clk),
        .rst(rst),
        .clr(bus.start),
        .shift(shift),
        .din(bus.data),
        .word(word),
        .idx(idx),
        .ready(we)
    );
    always_comb begin
        nx = state;
        if (bus.start) nx = HDR;
        else if (xfer)
            case (state)
                HDR: nx = bus.data == HDR_BYTE ? CNT_H : ERR;
                CNT_H: nx = CNT_L;
                CNT_L: nx = range_bad ? ERR : n_cl == 16'd0 ? CHK : DATA;
                DATA: nx = bad ? ERR : (last && wcnt + 17'd1 == {1'b0, n}) ? CHK : DATA;
                CHK: nx = bus.data == sum ? DONE : ERR;
                default: nx = state;
            endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            active <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            n <= '0;
            wcnt <= '0;
            sum <= '0;
            addr <= '0;
        end else begin
            state <= nx;
            active <= nx inside {HDR, CNT_H, CNT_L, DATA, CHK};
            done <= nx == DONE;
            error <= nx == ERR;
            if (bus.start) begin
                n <= '0;
                wcnt <= '0;
                sum <= '0;
            end else if (xfer) begin
                if (state == CNT_H) n[15:8] <= bus.data;
                if (state == CNT_L) n <= n_cl;
                if (shift) sum <= sum ^ bus.data;
                if (last) begin
                    addr <= BASE_ADDR + ADDR_WIDTH'(wcnt);
                    wcnt <= wcnt + 17'd1;
                end
            end
        end
    end
    assign bus.byte_ready = active;
    assign bus.cpu_hold = active;
    assign bus.done = done;
    assign bus.error = error;
    assign bus.write_enable = we;
    assign bus.write_address = addr;
    assign bus.write_instruction = word;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: table-driven and randomized frames checked against a frame-level reference model
module tb_instr_mem_loader;
    localparam int BASE = 'hFFF0;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int passes = 0;
    logic [43:0] got[$];
    instr_mem_loader_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(28)) bus ();
    instr_mem_loader #(.BASE_ADDR(16'(BASE))) dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.write_enable) got.push_back({bus.write_address, bus.write_instruction});

    typedef struct {
        logic [7:0] hdr;
        int n;
        int badw;
        bit flip;
        bit done;
        bit err;
        int nw;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // frame-level reference: parse per the frame rules, list the RAM writes and the final flags
    function automatic void model(input logic [7:0] f[$], output bit d, output bit e, output logic [43:0] w[$]);
        int n;
        logic [7:0] x;
        logic [31:0] wd;
        w = {};
        d = 0;
        e = 1;
        x = 0;
        if (f[0] != 8'hA5) return;
        n = int'({f[1], f[2]});
        if (n + BASE > 65536) return;
        for (int i = 0; i < n; i++) begin
            if (f[3+4*i] > 8'h0F) return;
            wd = {f[3+4*i], f[4+4*i], f[5+4*i], f[6+4*i]};
            w.push_back({16'(BASE + i), wd[27:0]});
            x ^= f[3+4*i] ^ f[4+4*i] ^ f[5+4*i] ^ f[6+4*i];
        end
        e = f[3+4*n] != x;
        d = !e;
    endfunction

    function automatic void build(input logic [7:0] hdr, input int n, input int badw, input bit flip,
                                  output logic [7:0] f[$]);
        logic [7:0] x, b;
        x = 0;
        f = {hdr, 8'(n >> 8), 8'(n)};
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                b = k != 0 ? 8'($urandom) : i == badw ? (8'h10 | 8'($urandom)) : 8'($urandom_range(0, 15));
                x ^= b;
                f.push_back(b);
            end
        f.push_back(flip ? ~x : x);
    endfunction

    task automatic send(input logic [7:0] f[$]);
        foreach (f[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (!bus.byte_ready) break;
            bus.byte_valid = 1;
            bus.data = f[i];
            @(negedge clk);
            bus.byte_valid = 0;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
    endtask

    task automatic run(input string nm, input logic [7:0] f[$], input bit do_start);
        bit d, e;
        logic [43:0] w[$];
        model(f, d, e, w);
        got.delete();
        if (do_start) begin
            pulse_start();
            chk({nm, " hold_after_start"}, 64'(bus.cpu_hold), 1);
        end
        send(f);
        repeat (3) @(negedge clk);
        chk({nm, " done"}, 64'(bus.done), 64'(d));
        chk({nm, " error"}, 64'(bus.error), 64'(e));
        chk({nm, " hold_end"}, 64'(bus.cpu_hold), 0);
        chk({nm, " ready_end"}, 64'(bus.byte_ready), 0);
        chk({nm, " nwrites"}, 64'(got.size()), 64'(w.size()));
        foreach (w[i]) chk({nm, " write"}, i < got.size() ? 64'(got[i]) : '1, 64'(w[i]));
    endtask

    initial begin
        logic [7:0] f[$];
        int n, fault, badw;
        tbl[0] = '{8'hA5, 2, -1, 0, 1, 0, 2};
        tbl[1] = '{8'hA5, 2, -1, 1, 0, 1, 2};
        tbl[2] = '{8'h5A, 2, -1, 0, 0, 1, 0};
        tbl[3] = '{8'hA5, 2, 0, 0, 0, 1, 0};
        tbl[4] = '{8'hA5, 0, -1, 0, 1, 0, 0};
        tbl[5] = '{8'hA5, 0, -1, 1, 0, 1, 0};
        tbl[6] = '{8'hA5, 3, 2, 0, 0, 1, 2};
        tbl[7] = '{8'hA5, 16, -1, 0, 1, 0, 16};
        tbl[8] = '{8'hA5, 17, -1, 0, 0, 1, 0};
        bus.start = 0;
        bus.byte_valid = 0;
        bus.data = 0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {bus.byte_ready, bus.write_enable, bus.cpu_hold, bus.done, bus.error,
                              bus.write_address, bus.write_instruction}, 0);
        rst = 0;
        @(negedge clk);
        chk("idle ready", 64'(bus.byte_ready), 0);

        f = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h12, 8'h34, 8'h56, 8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'hE9};
        run("spec frame", f, 1);
        chk("spec done", 64'(bus.done), 1);
        chk("spec w0", got.size() > 0 ? 64'(got[0]) : '1, {16'(BASE), 28'h1123456});
        chk("spec w1", got.size() > 1 ? 64'(got[1]) : '1, {16'(BASE + 1), 28'hABCDEF0});
        f[11] = 8'h16;
        run("spec bad chk", f, 1);
        chk("spec bad chk error", 64'(bus.error), 1);
        chk("spec bad chk nw", 64'(got.size()), 2);
        run("empty ok", {8'hA5, 8'h00, 8'h00, 8'h00}, 1);
        chk("empty ok done", 64'(bus.done), 1);
        run("empty bad", {8'hA5, 8'h00, 8'h00, 8'h01}, 1);
        chk("empty bad error", 64'(bus.error), 1);

        foreach (tbl[i]) begin
            build(tbl[i].hdr, tbl[i].n, tbl[i].badw, tbl[i].flip, f);
            run($sformatf("vec%0d", i), f, 1);
            chk($sformatf("vec%0d tbl_done", i), 64'(bus.done), 64'(tbl[i].done));
            chk($sformatf("vec%0d tbl_err", i), 64'(bus.error), 64'(tbl[i].err));
            chk($sformatf("vec%0d tbl_nw", i), 64'(got.size()), 64'(tbl[i].nw));
        end

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 17);
            fault = $urandom_range(0, 3);
            badw = fault == 3 ? $urandom_range(0, n) : -1;
            build(fault == 2 ? 8'h5A : 8'hA5, n, badw, fault == 1, f);
            run($sformatf("rand%0d", r), f, 1);
        end

        // restart in mid-DATA with a byte offered in the same cycle as start
        got.delete();
        pulse_start();
        f = {8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        foreach (f[i]) begin
            bus.byte_valid = 1;
            bus.data = f[i];
            @(negedge clk);
        end
        bus.start = 1;
        bus.data = 8'h07;
        @(negedge clk);
        bus.start = 0;
        bus.byte_valid = 0;
        chk("abort nw", 64'(got.size()), 1);
        chk("abort hold", 64'(bus.cpu_hold), 1);
        chk("abort flags", {bus.done, bus.error}, 0);
        build(8'hA5, 1, -1, 0, f);
        run("after abort", f, 0);
        chk("after abort addr", got.size() > 0 ? 64'(got[0][43:28]) : '1, 64'(BASE));

        // asynchronous reset while a write strobe is high
        pulse_start();
        f = {8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (f[i]) begin
            bus.byte_valid = 1;
            bus.data = f[i];
            @(negedge clk);
        end
        bus.byte_valid = 0;
        chk("pre-reset we", 64'(bus.write_enable), 1);
        #1 rst = 1;
        #1 chk("async reset outputs", {bus.byte_ready, bus.write_enable, bus.cpu_hold, bus.done, bus.error,
                                       bus.write_address, bus.write_instruction}, 0);
        @(negedge clk);
        rst = 0;
        got.delete();
        bus.byte_valid = 1;
        bus.data = 8'hA5;
        repeat (4) @(negedge clk);
        bus.byte_valid = 0;
        chk("post-reset ready", 64'(bus.byte_ready), 0);
        chk("post-reset hold", 64'(bus.cpu_hold), 0);
        chk("post-reset nw", 64'(got.size()), 0);
        chk("post-reset flags", {bus.done, bus.error}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
